// File: rtl/cic_decim_param.sv
// Parametrised CIC decimator: N integrators at the input rate, N combs at the decimated rate,
// valid/ready result port with sticky overrun. Optional feature macro: CIC_ROUND_EN (round + saturate).
module cic_decim_param #(
  parameter int N_STAGES = 5,
  parameter int R_MAX    = 256,
  parameter int IN_W     = 1,
  parameter int OUT_W    = 24,
  localparam int RW      = $clog2(R_MAX),
  localparam int IN_EFF  = (IN_W == 1) ? 2 : IN_W,
  localparam int ACC_W   = IN_EFF + N_STAGES * RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic [RW:0]      dec_ratio,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overrun
);
  localparam int DROP = ACC_W - OUT_W;
  localparam logic [RW:0] RATIO_MIN = (RW+1)'(2);
  localparam logic [RW:0] RATIO_MAX = (RW+1)'(R_MAX);

  logic [ACC_W-1:0] in_ext_s;
  logic [RW:0]      ratio_clamp_s;
  logic [RW:0]      cnt_r;
  logic [RW:0]      ratio_r;
  logic             tick_s;
  logic [ACC_W-1:0] comb_y_s;
  logic             comb_v_s;
  logic [OUT_W-1:0] res_s;
  logic             res_v_s;
  logic             load_s;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic             overrun_r;

  // Bitstream bits map to +1/-1; multi-bit samples are sign-extended
  always_comb begin
    if (IN_W == 1) begin
      in_ext_s = in_data[0] ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
    end else begin
      in_ext_s = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    end
  end

  // Requested ratio limited to the supported range
  always_comb begin
    if (dec_ratio < RATIO_MIN) begin
      ratio_clamp_s = RATIO_MIN;
    end else if (dec_ratio > RATIO_MAX) begin
      ratio_clamp_s = RATIO_MAX;
    end else begin
      ratio_clamp_s = dec_ratio;
    end
  end

  // ratio_r >= 2, so the frame's first sample can never be its last
  assign tick_s = in_valid && (cnt_r == ratio_r - (RW+1)'(1));

  // Frame counter; the ratio is sampled only at the start of each frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {(RW+1){1'b0}};
      ratio_r <= RATIO_MAX;
    end else if (in_valid) begin
      if (cnt_r == {(RW+1){1'b0}}) ratio_r <= ratio_clamp_s;
      cnt_r <= tick_s ? {(RW+1){1'b0}} : cnt_r + (RW+1)'(1);
    end
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_int
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] nxt_s;
    if (g == 0) begin : g_first
      assign nxt_s = acc_r + in_ext_s;
    end else begin : g_next
      assign nxt_s = acc_r + g_int[g-1].nxt_s;
    end
    // Integrator stage, chained combinationally so all stages settle in one clk
    always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_r <= {ACC_W{1'b0}};
      else if (in_valid) acc_r <= nxt_s;
    end
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    logic [ACC_W-1:0] x_s;
    logic             xv_s;
    logic [ACC_W-1:0] dly_r;
    logic [ACC_W-1:0] y_r;
    logic             v_r;
    if (g == 0) begin : g_first
      assign x_s  = g_int[N_STAGES-1].nxt_s;
      assign xv_s = tick_s;
    end else begin : g_next
      assign x_s  = g_comb[g-1].y_r;
      assign xv_s = g_comb[g-1].v_r;
    end
    // Comb stage: difference against the previous decimated value
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dly_r <= {ACC_W{1'b0}};
        y_r   <= {ACC_W{1'b0}};
        v_r   <= 1'b0;
      end else begin
        v_r <= xv_s;
        if (xv_s) begin
          y_r   <= x_s - dly_r;
          dly_r <= x_s;
        end
      end
    end
  end

  assign comb_y_s = g_comb[N_STAGES-1].y_r;
  assign comb_v_s = g_comb[N_STAGES-1].v_r;

`ifdef CIC_ROUND_EN
  localparam int HS = (DROP > 0) ? DROP - 1 : 0;
  localparam logic [ACC_W:0] HALF = (DROP > 0) ? ((ACC_W+1)'(1) << HS) : (ACC_W+1)'(0);

  function automatic logic [OUT_W-1:0] round_sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] sum;
    logic [OUT_W:0] top;
    sum = {acc[ACC_W-1], acc} + HALF;
    top = sum[ACC_W -: OUT_W+1];
    if (!top[OUT_W] && top[OUT_W-1]) begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      return top[OUT_W-1:0];
    end
  endfunction

  logic [OUT_W-1:0] res_r;
  logic             res_v_r;

  // Rounding stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_r   <= {OUT_W{1'b0}};
      res_v_r <= 1'b0;
    end else begin
      res_v_r <= comb_v_s;
      if (comb_v_s) res_r <= round_sat(comb_y_s);
    end
  end

  assign res_s   = res_r;
  assign res_v_s = res_v_r;
`else
  assign res_s   = comb_y_s[ACC_W-1 -: OUT_W];
  assign res_v_s = comb_v_s;
  if (DROP > 0) begin : g_drop
    logic unused_s;
    assign unused_s = ^comb_y_s[DROP-1:0];
  end
`endif

  // A new result may replace the held one only when that one leaves this clk
  assign load_s = res_v_s && (!out_valid_r || out_ready);

  // Output register, handshake and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      overrun_r   <= 1'b0;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= res_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (res_v_s && out_valid_r && !out_ready) overrun_r <= 1'b1;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign overrun   = overrun_r;

endmodule
